// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the CPU bus arbiter: FSM state encoding,
// requester indices and a small pointer-wrap helper.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GRANT  = 2'd1,
        ARB_LOCKED = 2'd2,
        ARB_TURN   = 2'd3
    } arb_state_t;

    localparam int REQ_DEC = 0;
    localparam int REQ_PC  = 1;
    localparam int REQ_REG = 2;
    localparam int REQ_ALU = 3;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 == n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/lock inputs and grant/status outputs of the bus arbiter.
// The arbiter connects through the master modport, requesters through slave.
interface bus_arbiter_if #(
    parameter int N_REQ = 4
) ();
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0] i_req;
    logic [N_REQ-1:0] i_lock;
    logic [N_REQ-1:0] o_grant;
    logic [ID_W-1:0]  o_owner_id;
    logic             o_bus_busy;
    logic             o_locked;
    logic             o_timeout;

    modport master (
        input  i_req, i_lock,
        output o_grant, o_owner_id, o_bus_busy, o_locked, o_timeout
    );

    modport slave (
        output i_req, i_lock,
        input  o_grant, o_owner_id, o_bus_busy, o_locked, o_timeout
    );
endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// Round-robin picker: first set request at or above 'start', wrapping around.
// Rotating a doubled copy of the request vector turns it into a plain priority encoder.
module rr_picker #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] start,
    output logic            valid,
    output logic [ID_W-1:0] index
);
    localparam int SUM_W = ID_W + 1;

    logic [N-1:0]     rotated;
    logic [ID_W-1:0]  offset;
    logic [SUM_W-1:0] sum;

    always_comb begin
        rotated = N'({req, req} >> start);
        valid   = 1'b0;
        offset  = '0;
        // Scanning downward lets the lowest set bit win.
        for (int i = N - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                valid  = 1'b1;
                offset = ID_W'(i);
            end
        end
        sum = {1'b0, start} + {1'b0, offset};
        if (sum >= SUM_W'(N)) begin
            sum = sum - SUM_W'(N);
        end
        index = sum[ID_W-1:0];
    end
endmodule

// File: rtl/bus_arbiter.sv
// Round-robin CPU bus arbiter with bus lock, lock timeout and a one-cycle
// turnaround between owners so tri-state drivers never overlap.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int QUANTUM = 8,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic           clk,
    input  logic           rst,
    bus_arbiter_if.master  bus
);
    localparam int ID_W = $clog2(N_REQ);
    localparam logic [CNT_W-1:0] Q_LAST = CNT_W'(QUANTUM - 1);
    localparam logic [CNT_W-1:0] T_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t       state, state_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_nxt;
    logic [ID_W-1:0]  rr_ptr, ptr_nxt;
    logic [ID_W-1:0]  owner, owner_nxt;
    logic             timeout_nxt;
    logic             release_bus;

    logic             pick_valid;
    logic [ID_W-1:0]  pick_idx;
    logic             own_req, own_lock, others_pending;

    logic [N_REQ-1:0] grant_d, grant_q;
    logic             locked_d, locked_q;
    logic             busy_d, busy_q;
    logic             timeout_q;

    rr_picker #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_picker (
        .req   (bus.i_req),
        .start (rr_ptr),
        .valid (pick_valid),
        .index (pick_idx)
    );

    assign own_req        = bus.i_req[owner];
    assign own_lock       = bus.i_lock[owner];
    assign others_pending = |(bus.i_req & ~(N_REQ'(1) << owner));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ARB_IDLE;
            hold_cnt  <= '0;
            rr_ptr    <= '0;
            owner     <= '0;
            grant_q   <= '0;
            locked_q  <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_nxt;
            rr_ptr    <= ptr_nxt;
            owner     <= owner_nxt;
            grant_q   <= grant_d;
            locked_q  <= locked_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        hold_nxt    = hold_cnt;
        ptr_nxt     = rr_ptr;
        owner_nxt   = owner;
        timeout_nxt = 1'b0;
        release_bus = 1'b0;
        case (state)
            ARB_IDLE, ARB_TURN: begin
                if (pick_valid) begin
                    state_nxt = ARB_GRANT;
                    owner_nxt = pick_idx;
                    hold_nxt  = '0;
                end else begin
                    state_nxt = ARB_IDLE;
                end
            end
            ARB_GRANT: begin
                if (!own_req) begin
                    release_bus = 1'b1;
                end else if (own_lock) begin
                    state_nxt = ARB_LOCKED;
                    hold_nxt  = '0;
                end else if (others_pending) begin
                    if (hold_cnt == Q_LAST) release_bus = 1'b1;
                    else                    hold_nxt    = hold_cnt + CNT_W'(1);
                end
            end
            ARB_LOCKED: begin
                // Dropping the request always wins; an unlock beats the timeout.
                if (!own_req) begin
                    release_bus = 1'b1;
                end else if (!own_lock) begin
                    state_nxt = ARB_GRANT;
                    hold_nxt  = '0;
                end else if (hold_cnt == T_LAST) begin
                    release_bus = 1'b1;
                    timeout_nxt = 1'b1;
                end else begin
                    hold_nxt = hold_cnt + CNT_W'(1);
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
        if (release_bus) begin
            state_nxt = ARB_TURN;
            hold_nxt  = '0;
            ptr_nxt   = ID_W'(wrap_inc(32'(owner), N_REQ));
        end
    end

    always_comb begin
        busy_d   = (state_nxt == ARB_GRANT) || (state_nxt == ARB_LOCKED);
        locked_d = (state_nxt == ARB_LOCKED);
        grant_d  = busy_d ? (N_REQ'(1) << owner_nxt) : '0;
    end

    assign bus.o_grant    = grant_q;
    assign bus.o_owner_id = owner;
    assign bus.o_bus_busy = busy_q;
    assign bus.o_locked   = locked_q;
    assign bus.o_timeout  = timeout_q;
endmodule
